// File: rtl/fifo_level.sv
// fifo_level: single-clock FIFO with guarded push/pop, exact fill level,
// almost-full/almost-empty thresholds, sticky error flags and an optional
// show-ahead (first-word-fall-through) read port.
//
// Handshake: wr_en_i and rd_en_i are requests, not commands. A push is
// accepted (push_ok) when the FIFO is not full, or when a pop is accepted
// in the same cycle. A pop is accepted (pop_ok) only when the FIFO is not
// empty. Rejected requests change no state except the sticky error flags.
// In standard mode, rd_valid_o pulses for one cycle, on the cycle after
// the accepted pop. In show-ahead mode, rd_valid_o/rd_data_o present the
// head word, and rd_en_i acknowledges it.
module fifo_level #(
    parameter int DEPTH_WIDTH  = 4,
    parameter int DATA_WIDTH   = 8,
    parameter bit FWFT         = 1'b0,
    parameter int AFULL_LEVEL  = (2 ** DEPTH_WIDTH) - 2,
    parameter int AEMPTY_LEVEL = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] wr_data_i,
    input  logic                  wr_en_i,
    input  logic                  rd_en_i,
    input  logic                  err_clr_i,
    output logic [DATA_WIDTH-1:0] rd_data_o,
    output logic                  rd_valid_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o,
    output logic [DEPTH_WIDTH:0]  level_o,
    output logic                  overflow_o,
    output logic                  underflow_o
);

    localparam int DEPTH = 2 ** DEPTH_WIDTH;
    localparam int PW    = DEPTH_WIDTH + 1;

    localparam logic [PW-1:0] DEPTH_L  = PW'(DEPTH);
    localparam logic [PW-1:0] AFULL_L  = PW'(AFULL_LEVEL);
    localparam logic [PW-1:0] AEMPTY_L = PW'(AEMPTY_LEVEL);

    // Parameter sanity checks, evaluated at elaboration.
    if (DEPTH_WIDTH <= 0) begin : g_bad_depth
        $error("fifo_level: DEPTH_WIDTH must be > 0");
    end
    if (DATA_WIDTH <= 0) begin : g_bad_width
        $error("fifo_level: DATA_WIDTH must be > 0");
    end
    if (AFULL_LEVEL < 1 || AFULL_LEVEL > DEPTH) begin : g_bad_afull
        $error("fifo_level: AFULL_LEVEL out of range 1..DEPTH");
    end
    if (AEMPTY_LEVEL < 0 || AEMPTY_LEVEL > DEPTH - 1) begin : g_bad_aempty
        $error("fifo_level: AEMPTY_LEVEL out of range 0..DEPTH-1");
    end

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] level_q, level_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic push_ok;
    logic pop_ok;

    // Flags come only from the registered level, so they move on the same
    // edge as level_o and never combinationally from the request inputs.
    assign empty_o        = (level_q == '0);
    assign full_o         = (level_q == DEPTH_L);
    assign almost_full_o  = (level_q >= AFULL_L);
    assign almost_empty_o = (level_q <= AEMPTY_L);
    assign level_o        = level_q;
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    // Acceptance; a full FIFO still takes a push when a pop frees a slot.
    always_comb begin
        pop_ok  = rd_en_i & ~empty_o;
        push_ok = wr_en_i & (~full_o | pop_ok);
    end

    // Next-state for pointers, level and sticky error flags.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            level_d = level_q + PW'(1);
        end else if (pop_ok && !push_ok) begin
            level_d = level_q - PW'(1);
        end

        // Clear first, so a coinciding new error event wins.
        if (err_clr_i) begin
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end
        if (wr_en_i && !push_ok) begin
            overflow_d = 1'b1;
        end
        if (rd_en_i && !pop_ok) begin
            underflow_d = 1'b1;
        end
    end

    // Control state register with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; written only on an accepted push, never reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[DEPTH_WIDTH-1:0]] <= wr_data_i;
        end
    end

    if (FWFT) begin : g_fwft
        // Show-ahead: the head word is presented directly from the array.
        always_comb begin
            rd_data_o  = mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];
            rd_valid_o = ~empty_o;
        end
    end else begin : g_std
        logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
        logic                  rd_valid_q, rd_valid_d;

        // Registered read: load the head word on an accepted pop, else hold.
        always_comb begin
            rd_data_d  = rd_data_q;
            rd_valid_d = pop_ok;
            if (pop_ok) begin
                rd_data_d = mem_q[rd_ptr_q[DEPTH_WIDTH-1:0]];
            end
        end

        // Read port register with asynchronous reset.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_data_q  <= rd_data_d;
                rd_valid_q <= rd_valid_d;
            end
        end

        always_comb begin
            rd_data_o  = rd_data_q;
            rd_valid_o = rd_valid_q;
        end
    end

endmodule

// File: tb/tb_fifo_level.sv
// Bench for fifo_level: one standard-read and one show-ahead instance share
// the same stimulus and are checked against a queue-based reference model.
module tb_fifo_level;

    localparam int DW     = 8;
    localparam int AW     = 2;
    localparam int DEPTH  = 4;
    localparam int AFULL  = 2;
    localparam int AEMPTY = 1;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [DW-1:0] wr_data = '0;
    logic          wr_en = 1'b0;
    logic          rd_en = 1'b0;
    logic          err_clr = 1'b0;

    logic [DW-1:0] s_rd_data, f_rd_data;
    logic          s_rd_valid, f_rd_valid;
    logic          s_full, f_full, s_empty, f_empty;
    logic          s_afull, f_afull, s_aempty, f_aempty;
    logic [AW:0]   s_level, f_level;
    logic          s_ovf, f_ovf, s_unf, f_unf;

    fifo_level #(.DEPTH_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1'b0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_data_i(wr_data), .wr_en_i(wr_en),
        .rd_en_i(rd_en), .err_clr_i(err_clr), .rd_data_o(s_rd_data),
        .rd_valid_o(s_rd_valid), .full_o(s_full), .empty_o(s_empty),
        .almost_full_o(s_afull), .almost_empty_o(s_aempty), .level_o(s_level),
        .overflow_o(s_ovf), .underflow_o(s_unf)
    );

    fifo_level #(.DEPTH_WIDTH(AW), .DATA_WIDTH(DW), .FWFT(1'b1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_data_i(wr_data), .wr_en_i(wr_en),
        .rd_en_i(rd_en), .err_clr_i(err_clr), .rd_data_o(f_rd_data),
        .rd_valid_o(f_rd_valid), .full_o(f_full), .empty_o(f_empty),
        .almost_full_o(f_afull), .almost_empty_o(f_aempty), .level_o(f_level),
        .overflow_o(f_ovf), .underflow_o(f_unf)
    );

    // ---------------- scoreboard / reference model ----------------
    logic [DW-1:0] exp_q[$];
    logic          exp_ovf;
    logic          exp_unf;
    logic          exp_rdv;
    logic [DW-1:0] exp_rd;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic reset_model();
        exp_q.delete();
        exp_ovf = 1'b0;
        exp_unf = 1'b0;
        exp_rdv = 1'b0;
        exp_rd  = '0;
    endtask

    // Apply one clock edge's worth of FIFO rules to the queue model.
    task automatic model_edge();
        bit pop_ok, push_ok;
        pop_ok  = rd_en && (exp_q.size() > 0);
        push_ok = wr_en && ((exp_q.size() < DEPTH) || pop_ok);
        exp_rdv = pop_ok;
        if (pop_ok) exp_rd = exp_q.pop_front();
        if (push_ok) exp_q.push_back(wr_data);
        if (err_clr) begin
            exp_ovf = 1'b0;
            exp_unf = 1'b0;
        end
        if (wr_en && !push_ok) exp_ovf = 1'b1;
        if (rd_en && !pop_ok) exp_unf = 1'b1;
    endtask

    task automatic check_all();
        int lvl;
        lvl = exp_q.size();
        check("s_level",    32'(s_level),    32'(lvl));
        check("s_full",     32'(s_full),     32'(lvl == DEPTH));
        check("s_empty",    32'(s_empty),    32'(lvl == 0));
        check("s_afull",    32'(s_afull),    32'(lvl >= AFULL));
        check("s_aempty",   32'(s_aempty),   32'(lvl <= AEMPTY));
        check("s_ovf",      32'(s_ovf),      32'(exp_ovf));
        check("s_unf",      32'(s_unf),      32'(exp_unf));
        check("s_rd_valid", 32'(s_rd_valid), 32'(exp_rdv));
        check("s_rd_data",  32'(s_rd_data),  32'(exp_rd));
        check("f_level",    32'(f_level),    32'(lvl));
        check("f_full",     32'(f_full),     32'(lvl == DEPTH));
        check("f_empty",    32'(f_empty),    32'(lvl == 0));
        check("f_afull",    32'(f_afull),    32'(lvl >= AFULL));
        check("f_aempty",   32'(f_aempty),   32'(lvl <= AEMPTY));
        check("f_ovf",      32'(f_ovf),      32'(exp_ovf));
        check("f_unf",      32'(f_unf),      32'(exp_unf));
        check("f_rd_valid", 32'(f_rd_valid), 32'(lvl > 0));
        if (lvl > 0) check("f_rd_data", 32'(f_rd_data), 32'(exp_q[0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step(input logic we, input logic [DW-1:0] wd, input logic re, input logic clr);
        wr_en   = we;
        wr_data = wd;
        rd_en   = re;
        err_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        err_clr = 1'b0;
    endtask

    task automatic push(input logic [DW-1:0] d);
        step(1'b1, d, 1'b0, 1'b0);
    endtask

    task automatic pop();
        step(1'b0, '0, 1'b1, 1'b0);
    endtask

    // Assert reset between edges, check outputs before any clock edge,
    // hold through one edge, then release.
    task automatic async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        reset_model();
        check_all();
        @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        reset_model();
        repeat (2) @(posedge clk);
        #1;
        check_all();
        rst_n = 1'b1;

        // Fill to full, then one overflowing push.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        push(8'h66);
        step(1'b0, '0, 1'b0, 1'b1);

        // Push and pop together while full.
        step(1'b1, 8'h55, 1'b1, 1'b0);
        repeat (4) pop();

        // Underflow, clear, and clear colliding with a new underflow.
        pop();
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1);

        // Single word through an empty FIFO.
        push(8'hA5);
        step(1'b0, '0, 1'b0, 1'b0);
        pop();

        // Push and pop together while empty.
        step(1'b1, 8'h3C, 1'b1, 1'b0);
        pop();
        step(1'b0, '0, 1'b0, 1'b1);

        // Pointer wrap-around.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 3; k++) push(8'($urandom_range(0, 255)));
            for (int k = 0; k < 3; k++) pop();
        end

        // Reset mid-stream at level 3, then resume.
        for (int k = 0; k < 3; k++) push(8'($urandom_range(0, 255)));
        async_reset();
        push(8'hC1);
        push(8'hC2);
        pop();
        pop();

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
